// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: stimulus/config in, per-period results out.
// The master side is the capture block; the slave side drives the PWM pair and consumes results.
interface pwm_capture_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             pwm_in;
  logic             pwm_cmp_in;
  logic [WIDTH-1:0] timeout;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic [WIDTH-1:0] dead_fall_out;
  logic [WIDTH-1:0] dead_rise_out;
  logic             cmp_seen;
  logic             valid;
  logic             timeout_flag;
  logic             stuck_level;

  modport master (
    input  enable, pwm_in, pwm_cmp_in, timeout,
    output period_out, high_out, dead_fall_out, dead_rise_out,
    output cmp_seen, valid, timeout_flag, stuck_level
  );

  modport slave (
    output enable, pwm_in, pwm_cmp_in, timeout,
    input  period_out, high_out, dead_fall_out, dead_rise_out,
    input  cmp_seen, valid, timeout_flag, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Complementary PWM pair capture: period, high time and both dead-time gaps per period.
// Results publish one cycle after the synchronized pwm_in rise; no backpressure, valid is a single-cycle pulse.
module pwm_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  pwm_capture_if.master  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [SYNC_STAGES-1:0] p_sync, c_sync;
  logic                   p_prev, c_prev;
  logic                   p_s, c_s;
  logic                   p_rise, p_fall, c_rise, c_fall;
  logic                   timeout_hit;

  logic [WIDTH-1:0] pcnt, dcnt, rcnt;
  logic [WIDTH-1:0] high_cap, dfall_cap;
  logic             cmp_seen_cap, cmp_fell;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  assign p_s    = p_sync[SYNC_STAGES-1];
  assign c_s    = c_sync[SYNC_STAGES-1];
  assign p_rise = p_s & ~p_prev;
  assign p_fall = ~p_s & p_prev;
  assign c_rise = c_s & ~c_prev;
  assign c_fall = ~c_s & c_prev;
  // A pwm_in edge on the same cycle always takes precedence over the timeout.
  assign timeout_hit = (bus.timeout != '0) && (pcnt == bus.timeout) && !p_rise && !p_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_sync <= '0;
      c_sync <= '0;
      p_prev <= 1'b0;
      c_prev <= 1'b0;
    end else begin
      p_sync[0] <= bus.pwm_in;
      c_sync[0] <= bus.pwm_cmp_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        p_sync[i] <= p_sync[i-1];
        c_sync[i] <= c_sync[i-1];
      end
      p_prev <= p_s;
      c_prev <= c_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pcnt              <= '0;
      dcnt              <= '0;
      rcnt              <= '0;
      high_cap          <= '0;
      dfall_cap         <= '0;
      cmp_seen_cap      <= 1'b0;
      cmp_fell          <= 1'b0;
      bus.period_out    <= '0;
      bus.high_out      <= '0;
      bus.dead_fall_out <= '0;
      bus.dead_rise_out <= '0;
      bus.cmp_seen      <= 1'b0;
      bus.valid         <= 1'b0;
      bus.timeout_flag  <= 1'b0;
      bus.stuck_level   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (!bus.enable || (state != IDLE && timeout_hit)) begin
        state        <= IDLE;
        pcnt         <= '0;
        dcnt         <= '0;
        rcnt         <= '0;
        high_cap     <= '0;
        dfall_cap    <= '0;
        cmp_seen_cap <= 1'b0;
        cmp_fell     <= 1'b0;
        if (bus.enable) begin
          bus.timeout_flag <= 1'b1;
          bus.stuck_level  <= p_s;
        end
      end else begin
        case (state)
          IDLE: begin
            pcnt <= '0;
            if (p_rise) begin
              state <= HIGH;
              pcnt  <= ONE;
            end
          end
          HIGH: begin
            pcnt <= sat_inc(pcnt);
            if (p_fall) begin
              state    <= LOW;
              high_cap <= pcnt;
              dcnt     <= ONE;
              // cmp rising together with the pwm fall is a zero dead-time event.
              if (c_rise) begin
                dfall_cap    <= '0;
                cmp_seen_cap <= 1'b1;
              end
            end
          end
          LOW: begin
            pcnt <= sat_inc(pcnt);
            dcnt <= sat_inc(dcnt);
            if (cmp_fell) rcnt <= sat_inc(rcnt);
            if (p_rise) begin
              state             <= HIGH;
              pcnt              <= ONE;
              bus.period_out    <= pcnt;
              bus.high_out      <= high_cap;
              bus.dead_fall_out <= dfall_cap;
              bus.dead_rise_out <= (cmp_fell && cmp_seen_cap && !c_fall) ? rcnt : '0;
              bus.cmp_seen      <= cmp_seen_cap;
              bus.timeout_flag  <= 1'b0;
              bus.valid         <= 1'b1;
              dcnt              <= '0;
              rcnt              <= '0;
              high_cap          <= '0;
              dfall_cap         <= '0;
              cmp_seen_cap      <= 1'b0;
              cmp_fell          <= 1'b0;
            end else begin
              if (c_rise && !cmp_seen_cap) begin
                dfall_cap    <= dcnt;
                cmp_seen_cap <= 1'b1;
              end
              if (c_fall) begin
                rcnt     <= ONE;
                cmp_fell <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM pairs cycle by cycle and checks published measurements.
module tb_pwm_capture;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   vcnt;
  int   v_last;
  int   v_gap;
  int   base;
  bit   first_armed;
  logic [31:0] v_period, v_high, v_df, v_dr, v_first;
  logic        v_cmp;

  pwm_capture_if #(.WIDTH(32)) bus ();

  pwm_capture #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and record any valid pulse seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.valid === 1'b1) begin
      vcnt++;
      v_period = bus.period_out;
      v_high   = bus.high_out;
      v_df     = bus.dead_fall_out;
      v_dr     = bus.dead_rise_out;
      v_cmp    = bus.cmp_seen;
      v_gap    = cyc - v_last;
      v_last   = cyc;
      if (first_armed) begin
        v_first     = bus.period_out;
        first_armed = 1'b0;
      end
    end
  endtask

  task automatic run_period(input int per, input int hi, input int df, input int dr, input bit cmp_on);
    for (int i = 0; i < per; i++) begin
      bus.pwm_in     = (i < hi);
      bus.pwm_cmp_in = cmp_on && (i >= hi + df) && (i < per - dr);
      tick();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; vcnt = 0; v_last = 0; v_gap = 0;
    first_armed = 1'b0; v_first = '0;
    v_period = '0; v_high = '0; v_df = '0; v_dr = '0; v_cmp = 1'b0;
    reset = 1'b1;
    bus.enable = 1'b1; bus.pwm_in = 1'b0; bus.pwm_cmp_in = 1'b0; bus.timeout = '0;
    repeat (3) tick();
    check("rst_period", bus.period_out, 0);
    check("rst_high", bus.high_out, 0);
    check("rst_valid", {31'd0, bus.valid}, 0);
    check("rst_flag", {31'd0, bus.timeout_flag}, 0);
    reset = 1'b0;
    repeat (4) tick();

    // Complementary pair, 20/8 with 2-cycle dead times.
    repeat (6) run_period(20, 8, 2, 2, 1'b1);
    check("t1_count", vcnt, 5);
    check("t1_period", v_period, 20);
    check("t1_high", v_high, 8);
    check("t1_dfall", v_df, 2);
    check("t1_drise", v_dr, 2);
    check("t1_cmp", {31'd0, v_cmp}, 1);
    check("t1_gap", v_gap, 20);

    // Zero dead time: edges coincide.
    base = vcnt;
    repeat (4) run_period(10, 5, 0, 0, 1'b1);
    check("t2_count", vcnt, base + 4);
    check("t2_period", v_period, 10);
    check("t2_high", v_high, 5);
    check("t2_dfall", v_df, 0);
    check("t2_drise", v_dr, 0);
    check("t2_cmp", {31'd0, v_cmp}, 1);
    check("t2_gap", v_gap, 10);

    // Timeout with pwm stuck high.
    bus.timeout = 32'd50;
    repeat (2) run_period(20, 8, 2, 2, 1'b1);
    bus.pwm_in = 1'b1; bus.pwm_cmp_in = 1'b0;
    base = vcnt;
    for (int i = 0; i < 10 && vcnt == base; i++) tick();
    check("t3_last_valid", vcnt, base + 1);
    check("t3_last_period", v_period, 20);
    base = vcnt;
    repeat (49) tick();
    check("t3_flag_early", {31'd0, bus.timeout_flag}, 0);
    tick();
    check("t3_flag", {31'd0, bus.timeout_flag}, 1);
    check("t3_stuck", {31'd0, bus.stuck_level}, 1);
    repeat (20) tick();
    check("t3_no_valid", vcnt, base);
    bus.pwm_in = 1'b0;
    repeat (4) tick();
    run_period(20, 8, 2, 2, 1'b1);
    check("t3_flag_sticky", {31'd0, bus.timeout_flag}, 1);
    repeat (2) run_period(20, 8, 2, 2, 1'b1);
    check("t3_recover_count", vcnt, base + 2);
    check("t3_flag_clear", {31'd0, bus.timeout_flag}, 0);

    // pwm_cmp_in held low.
    base = vcnt;
    repeat (4) run_period(16, 4, 0, 0, 1'b0);
    check("t4_count", vcnt, base + 4);
    check("t4_period", v_period, 16);
    check("t4_high", v_high, 4);
    check("t4_dfall", v_df, 0);
    check("t4_drise", v_dr, 0);
    check("t4_cmp", {31'd0, v_cmp}, 0);

    // Reset during HIGH of the third period.
    repeat (2) run_period(20, 8, 2, 2, 1'b1);
    bus.pwm_in = 1'b1; bus.pwm_cmp_in = 1'b0;
    repeat (4) tick();
    reset = 1'b1; bus.pwm_in = 1'b0;
    tick();
    check("t5_rst_period", bus.period_out, 0);
    check("t5_rst_high", bus.high_out, 0);
    check("t5_rst_dfall", bus.dead_fall_out, 0);
    check("t5_rst_drise", bus.dead_rise_out, 0);
    check("t5_rst_cmp", {31'd0, bus.cmp_seen}, 0);
    check("t5_rst_stuck", {31'd0, bus.stuck_level}, 0);
    reset = 1'b0;
    repeat (3) tick();
    base = vcnt;
    run_period(20, 8, 2, 2, 1'b1);
    check("t5_no_valid_1rise", vcnt, base);
    run_period(20, 8, 2, 2, 1'b1);
    check("t5_valid_2rise", vcnt, base + 1);
    check("t5_period", v_period, 20);

    // Enable low mid-stream, then period change to 30.
    repeat (3) run_period(20, 8, 2, 2, 1'b1);
    base = vcnt;
    bus.enable = 1'b0; bus.pwm_in = 1'b0; bus.pwm_cmp_in = 1'b0;
    repeat (5) tick();
    check("t6_disabled_count", vcnt, base);
    check("t6_held_period", bus.period_out, 20);
    check("t6_held_high", bus.high_out, 8);
    bus.enable = 1'b1;
    first_armed = 1'b1;
    repeat (3) run_period(30, 8, 2, 2, 1'b1);
    check("t6_count", vcnt, base + 2);
    check("t6_first_period", v_first, 30);
    check("t6_period", v_period, 30);
    check("t6_drise", v_dr, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures a complementary PWM pair (pwm_in high-side, pwm_cmp_in low-side) on the same clk domain as the PWM generators.
- Per period, reports period, high time and both dead-time gaps in clk cycles.
- Used for closed-loop self-check of generated gate signals and for capturing external PWM.
- Flags loss of switching with a programmable timeout.

Parameters:
WIDTH, 32, width of all counters and measurement outputs
SYNC_STAGES, 2, synchronizer flops on each input (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable; low forces IDLE
pwm_in  in  1  high-side PWM input (asynchronous allowed)
pwm_cmp_in  in  1  complementary PWM input (asynchronous allowed)
timeout  in  WIDTH  max cycles without expected pwm_in edge; 0 disables
period_out  out  WIDTH  cycles between consecutive pwm_in rising edges
high_out  out  WIDTH  cycles from pwm_in rise to pwm_in fall
dead_fall_out  out  WIDTH  cycles from pwm_in fall to pwm_cmp_in rise
dead_rise_out  out  WIDTH  cycles from pwm_cmp_in fall to next pwm_in rise
cmp_seen  out  1  pwm_cmp_in rose during the reported period
valid  out  1  one-cycle pulse: outputs updated this cycle
timeout_flag  out  1  sticky: timeout occurred since last valid
stuck_level  out  1  synchronized pwm_in level at the last timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; synchronizers 0.
- Input path:
  - Each input passes SYNC_STAGES flops, then one "prev" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Fixed latency of SYNC_STAGES+1 cycles, identical for both inputs, so it cancels in all measurements.
- Main counter pcnt:
  - On a pwm_in rise cycle: pcnt <= 1.
  - Otherwise pcnt increments each cycle.
  - Saturates at 2^WIDTH-1; never wraps.
- State machine:
  - IDLE: counters held at 0. On pwm_in rise with enable=1 -> HIGH; pcnt <= 1. Partial first period is never reported.
  - HIGH: on pwm_in fall -> LOW; high_cap <= pcnt; dcnt <= 1 (dead-fall counter starts).
  - LOW:
    - On pwm_cmp_in rise (first in period): dead_fall_cap <= dcnt; cmp_seen_cap <= 1.
    - On pwm_cmp_in fall: rcnt <= 1 (dead-rise counter starts; it increments thereafter).
    - On pwm_in rise: publish; -> HIGH; pcnt <= 1; clear caps.
- Publish cycle (registered, valid=1 for exactly this cycle):
  - period_out <= pcnt; high_out <= high_cap.
  - dead_fall_out <= dead_fall_cap.
  - dead_rise_out <= rcnt if a pwm_cmp_in fall occurred in LOW, else 0.
  - cmp_seen <= cmp_seen_cap; timeout_flag <= 0.
- Simultaneous edges on one cycle:
  - pwm_in fall + pwm_cmp_in rise -> dead_fall=0.
  - pwm_cmp_in fall + pwm_in rise -> dead_rise=0.
- Overlap (pwm_cmp_in high while pwm_in high):
  - Not a dead-time event.
  - cmp edges in HIGH are ignored; cmp_seen reflects LOW only.
- pwm_cmp_in never rises in LOW (100%/0% duty cases): dead_fall_out=0, dead_rise_out=0, cmp_seen=0.
- Timeout: timeout!=0 and pcnt==timeout in HIGH or LOW, with no pwm_in edge that cycle:
  - timeout_flag <= 1; stuck_level <= synchronized pwm_in.
  - -> IDLE; no valid pulse.
  - Edge and timeout on the same cycle: the edge wins.
- enable=0: -> IDLE next cycle; counters cleared; measurement outputs and flags hold last values.
- Reset mid-measurement: abort immediately; everything returns to reset values.
- Outputs are stable between valid pulses.

Test Plan:
- Complementary pair, pwm period 20, high 8; cmp rises 2 after pwm fall, falls 2 before pwm rise -> from 2nd pwm rise on, valid every 20 cycles: period 20, high 8, dead_fall 2, dead_rise 2, cmp_seen 1.
- Edges on the same cycle (dead time 0), period 10, high 5 -> period 10, high 5, dead_fall 0, dead_rise 0, cmp_seen 1.
- pwm constant 1 after two good periods, timeout=50 -> timeout_flag=1 and stuck_level=1, exactly 50 cycles after last rise; no valid. Restore toggling -> flag clears on the next valid pulse.
- pwm_cmp_in held 0, pwm period 16, high 16-cycle-aligned 4 -> period 16, high 4, dead_fall 0, dead_rise 0, cmp_seen 0.
- Reset asserted during HIGH of 3rd period -> all outputs 0 the next cycle. First valid comes only after two new rises post-reset.
- Period changes 20 -> 30 between periods, with enable low for 5 cycles mid-stream -> no valid while disabled, outputs held. First valid after re-enable reports 30 (not a partial period).
